// File: rtl/reg_file.sv
// APB-programmable register file for the clustering core.
// Also drives one-cycle SRAM write pulses from the RAM_addr/RAM_data registers.
module reg_file #(
    parameter int addrWidth    = 9,
    parameter int dataWidth    = 91,
    parameter int reg_amount   = 4,
    parameter int ram_word_len = 50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [addrWidth-1:0] paddr,
    input  logic                 pwrite,
    input  logic                 psel,
    input  logic                 penable,
    input  logic [dataWidth-1:0] pwdata,
    output logic [dataWidth-1:0] prdata,
    output logic                 pready,
    input  logic [reg_amount-1:0] reg_num,
    input  logic                 reg_write,
    input  logic [dataWidth-1:0] reg_write_data,
    output logic                 interupt,
    output logic                 go_core,
    output logic                 w_r_ram_n,
    output logic                 out_en_ram_n,
    output logic                 chip_select_ram_n,
    output logic [dataWidth-1:0] data2core,
    output logic [addrWidth-1:0] address2core,
    output logic [addrWidth-1:0] first_ram_address_out,
    output logic [addrWidth-1:0] last_ram_address_out,
    output logic [dataWidth-1:0] threshold_value
);

    localparam int NREG = 15;

    localparam logic [3:0] A_STATUS = 4'd0;
    localparam logic [3:0] A_GO     = 4'd1;
    localparam logic [3:0] A_RADDR  = 4'd10;
    localparam logic [3:0] A_RDATA  = 4'd11;
    localparam logic [3:0] A_FIRST  = 4'd12;
    localparam logic [3:0] A_LAST   = 4'd13;
    localparam logic [3:0] A_THRESH = 4'd14;

    logic [dataWidth-1:0] regs_q [NREG];
    logic [dataWidth-1:0] regs_d [NREG];
    logic                 ram_wr_q;
    logic                 ram_wr_d;

    logic [3:0] apb_idx;
    logic [3:0] core_idx;
    logic       apb_map;
    logic       apb_we;
    logic       core_we;

    // Decode APB and core access targets; only go/status stay writable
    // over APB while the core is running.
    always_comb begin
        apb_idx  = paddr[3:0];
        core_idx = 4'(reg_num);
        apb_map  = paddr < addrWidth'(NREG);
        core_we  = reg_write && (reg_num < reg_amount'(NREG));
        apb_we   = psel && penable && pwrite && apb_map &&
                   (!regs_q[A_GO][0] || apb_idx <= A_GO);
    end

    // Next register state: APB first, then the core so the core wins a
    // same-cycle collision; a RAM_data APB write arms the SRAM pulse.
    always_comb begin
        regs_d   = regs_q;
        ram_wr_d = 1'b0;
        if (apb_we) begin
            regs_d[apb_idx] = pwdata;
            if (apb_idx == A_GO && pwdata[0]) begin
                regs_d[A_STATUS][0] = 1'b0;
            end
            if (apb_idx == A_RDATA) begin
                ram_wr_d = 1'b1;
            end
        end
        if (core_we) begin
            regs_d[core_idx] = reg_write_data;
            if (core_idx == A_STATUS && reg_write_data[0]) begin
                regs_d[A_GO] = '0;
            end
        end
    end

    // State registers with synchronous reset taking priority over writes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            ram_wr_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            ram_wr_q <= ram_wr_d;
        end
    end

    // APB read path and handshake, zero wait states.
    always_comb begin
        pready = psel && penable;
        prdata = '0;
        if (psel && !pwrite && apb_map) begin
            prdata = regs_q[apb_idx];
        end
    end

    // Core-facing and SRAM-facing outputs.
    always_comb begin
        go_core               = regs_q[A_GO][0];
        interupt              = regs_q[A_STATUS][0];
        chip_select_ram_n     = !ram_wr_q;
        w_r_ram_n             = !ram_wr_q;
        out_en_ram_n          = 1'b1;
        address2core          = regs_q[A_RADDR][addrWidth-1:0];
        data2core             = regs_q[A_RDATA];
        first_ram_address_out = regs_q[A_FIRST][addrWidth-1:0];
        last_ram_address_out  = regs_q[A_LAST][addrWidth-1:0];
        threshold_value       = regs_q[A_THRESH];
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// Drives APB and core writes at negedges, samples between edges.
module tb_reg_file;

    localparam int AW = 9;
    localparam int DW = 91;
    localparam int RW = 4;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic [RW-1:0] reg_num;
    logic          reg_write;
    logic [DW-1:0] reg_write_data;
    logic          interupt;
    logic          go_core;
    logic          w_r_ram_n;
    logic          out_en_ram_n;
    logic          chip_select_ram_n;
    logic [DW-1:0] data2core;
    logic [AW-1:0] address2core;
    logic [AW-1:0] first_ram_address_out;
    logic [AW-1:0] last_ram_address_out;
    logic [DW-1:0] threshold_value;

    int n_checks;
    int n_fail;

    reg_file #(
        .addrWidth(AW),
        .dataWidth(DW),
        .reg_amount(RW),
        .ram_word_len(50)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .paddr(paddr),
        .pwrite(pwrite),
        .psel(psel),
        .penable(penable),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .reg_num(reg_num),
        .reg_write(reg_write),
        .reg_write_data(reg_write_data),
        .interupt(interupt),
        .go_core(go_core),
        .w_r_ram_n(w_r_ram_n),
        .out_en_ram_n(out_en_ram_n),
        .chip_select_ram_n(chip_select_ram_n),
        .data2core(data2core),
        .address2core(address2core),
        .first_ram_address_out(first_ram_address_out),
        .last_ram_address_out(last_ram_address_out),
        .threshold_value(threshold_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        psel    = 1'b1;
        pwrite  = 1'b1;
        penable = 1'b0;
        paddr   = AW'(a);
        pwdata  = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_read(input int a, output logic [DW-1:0] d,
                            output logic rdy);
        @(negedge clk);
        psel    = 1'b1;
        pwrite  = 1'b0;
        penable = 1'b0;
        paddr   = AW'(a);
        @(negedge clk);
        penable = 1'b1;
        #1;
        d       = prdata;
        rdy     = pready;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic core_write(input int n, input logic [DW-1:0] d);
        @(negedge clk);
        reg_num        = RW'(n);
        reg_write      = 1'b1;
        reg_write_data = d;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    logic [DW-1:0] rd;
    logic          rdy;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b1;
        paddr          = '0;
        pwrite         = 1'b0;
        psel           = 1'b0;
        penable        = 1'b0;
        pwdata         = '0;
        reg_num        = '0;
        reg_write      = 1'b0;
        reg_write_data = '0;

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        check("rst_go_core", go_core, 0);
        check("rst_interupt", interupt, 0);
        check("rst_w_r_n", w_r_ram_n, 1);
        check("rst_cs_n", chip_select_ram_n, 1);
        check("rst_oe_n", out_en_ram_n, 1);
        check("rst_prdata", prdata, 0);
        check("rst_addr2core", address2core, 0);
        check("rst_data2core", data2core, 0);
        for (int i = 0; i < 15; i++) begin
            apb_read(i, rd, rdy);
            check($sformatf("rst_reg%0d", i), rd, 0);
        end

        apb_write(10, 1);
        check("idle_cs_n", chip_select_ram_n, 1);
        apb_write(11, 6);
        check("p1_cs_n", chip_select_ram_n, 0);
        check("p1_w_r_n", w_r_ram_n, 0);
        check("p1_addr", address2core, 1);
        check("p1_data", data2core, 6);
        check("p1_oe_n", out_en_ram_n, 1);
        @(negedge clk);
        check("p1_end_cs_n", chip_select_ram_n, 1);
        check("p1_end_w_r_n", w_r_ram_n, 1);
        apb_write(10, 2);
        apb_write(11, 12);
        check("p2_cs_n", chip_select_ram_n, 0);
        check("p2_addr", address2core, 2);
        check("p2_data", data2core, 12);

        @(negedge clk);
        psel    = 1'b1;
        pwrite  = 1'b1;
        paddr   = AW'(11);
        pwdata  = 20;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check("b2b1_cs_n", chip_select_ram_n, 0);
        check("b2b1_data", data2core, 20);
        pwdata = 21;
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        check("b2b2_cs_n", chip_select_ram_n, 0);
        check("b2b2_data", data2core, 21);
        @(negedge clk);
        check("b2b_end_cs_n", chip_select_ram_n, 1);

        apb_write(4, 'h1234);
        apb_read(4, rd, rdy);
        check("cent3_rd", rd, 'h1234);
        check("cent3_pready", rdy, 1);
        apb_read(20, rd, rdy);
        check("unmapped_rd", rd, 0);
        apb_write(15, 'hAA);
        apb_read(15, rd, rdy);
        check("unmapped15_rd", rd, 0);

        apb_write(12, 3);
        apb_write(13, 'h3FF);
        apb_write(14, 'hABC);
        check("first_out", first_ram_address_out, 3);
        check("last_out", last_ram_address_out, 'h1FF);
        check("thresh_out", threshold_value, 'hABC);
        apb_read(13, rd, rdy);
        check("last_rd_full", rd, 'h3FF);

        apb_write(1, 1);
        check("go_core_set", go_core, 1);
        apb_write(2, 5);
        apb_read(2, rd, rdy);
        check("cent1_locked", rd, 0);
        apb_write(11, 7);
        check("ram_locked_cs_n", chip_select_ram_n, 1);
        check("ram_locked_data", data2core, 21);

        core_write(0, 1);
        check("done_interupt", interupt, 1);
        check("done_go_clr", go_core, 0);
        apb_write(1, 1);
        check("restart_interupt", interupt, 0);
        check("restart_go", go_core, 1);
        apb_write(1, 0);
        check("abort_go", go_core, 0);

        @(negedge clk);
        psel    = 1'b1;
        pwrite  = 1'b1;
        paddr   = AW'(3);
        pwdata  = 3;
        @(negedge clk);
        penable        = 1'b1;
        reg_num        = RW'(3);
        reg_write      = 1'b1;
        reg_write_data = 9;
        @(negedge clk);
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        reg_write = 1'b0;
        apb_read(3, rd, rdy);
        check("collide_core_wins", rd, 9);

        apb_write(10, 5);
        apb_write(11, 33);
        check("mid_pulse_cs_n", chip_select_ram_n, 0);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check("rst_mid_cs_n", chip_select_ram_n, 1);
        check("rst_mid_addr", address2core, 0);

        @(negedge clk);
        psel    = 1'b1;
        pwrite  = 1'b1;
        paddr   = AW'(11);
        pwdata  = 44;
        @(negedge clk);
        penable = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        rst_n   = 1'b0;
        check("rst_prio_cs_n", chip_select_ram_n, 1);
        check("rst_prio_data", data2core, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
